// File: rtl/fp_divider_if.sv
// Operand/result bundle with valid/ready handshakes for the iterative FP divider.
interface fp_divider_if #(parameter int BIT_SIZE = 32);
  logic                in_valid;
  logic                in_ready;
  logic [BIT_SIZE-1:0] num0;
  logic [BIT_SIZE-1:0] num1;
  logic                out_valid;
  logic                out_ready;
  logic [BIT_SIZE-1:0] res;
  logic [4:0]          flags;

  modport master (output in_valid, num0, num1, out_ready,
                  input  in_ready, out_valid, res, flags);
  modport slave  (input  in_valid, num0, num1, out_ready,
                  output in_ready, out_valid, res, flags);
endinterface

// File: rtl/fp_divider.sv
// Iterative IEEE-754 binary32/binary64 divider: restoring radix-2 mantissa
// division, one quotient bit per cycle, one operation in flight.
module fp_divider #(
  parameter int BIT_SIZE      = 32,
  parameter int ROUNDING_TYPE = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  fp_divider_if.slave bus
);
  // state | meaning
  // IDLE  | ready for operands
  // ITER  | one restoring quotient bit per cycle
  // NORM  | normalize, round, apply special cases, register result
  // DONE  | result valid, held until consumer takes it
  localparam int E    = (BIT_SIZE == 64) ? 11 : 8;
  localparam int F    = (BIT_SIZE == 64) ? 52 : 23;
  localparam int BIAS = (1 << (E - 1)) - 1;
  localparam int EW   = E + 2;
  localparam int CW   = $clog2(F + 4);

  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << E) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;
  localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);

  generate
    if (BIT_SIZE != 32 && BIT_SIZE != 64) begin : g_bad_size
      $error("fp_divider: BIT_SIZE must be 32 or 64");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ITER, NORM, DONE} state_t;
  typedef enum logic [2:0] {SP_NONE, SP_NAN, SP_DZ, SP_INF, SP_ZERO} sp_t;

  state_t state, state_nxt;

  logic                s0, s1;
  logic [E-1:0]        e0, e1;
  logic [F-1:0]        f0, f1;
  logic                zero0, zero1, inf0, inf1, nan0, nan1;
  logic signed [EW-1:0] exp_in;
  sp_t                 sp_in;

  logic [F+1:0]        rem, dvs, rem_nxt;
  logic [F+2:0]        q;
  logic [CW-1:0]       cnt;
  logic                sign;
  logic signed [EW-1:0] exp_r;
  sp_t                 sp;
  logic                rem_ge;

  logic [BIT_SIZE-1:0] res_r, res_n;
  logic [4:0]          flags_r, flags_n;

  logic                msb, guard, round_up, inexact;
  logic [F-1:0]        frac;
  logic [F:0]          sig_rnd;
  logic signed [EW-1:0] exp_n, exp_f;

  assign s0 = bus.num0[BIT_SIZE-1];
  assign e0 = bus.num0[BIT_SIZE-2:F];
  assign f0 = bus.num0[F-1:0];
  assign s1 = bus.num1[BIT_SIZE-1];
  assign e1 = bus.num1[BIT_SIZE-2:F];
  assign f1 = bus.num1[F-1:0];

  // Subnormal inputs fall into the zero class.
  assign zero0 = (e0 == '0);
  assign zero1 = (e1 == '0);
  assign inf0  = (&e0) && (f0 == '0);
  assign inf1  = (&e1) && (f1 == '0);
  assign nan0  = (&e0) && (f0 != '0);
  assign nan1  = (&e1) && (f1 != '0);

  assign exp_in = $signed({2'b00, e0}) - $signed({2'b00, e1}) + EW'(BIAS);

  always_comb begin
    sp_in = SP_NONE;
    if (nan0 || nan1 || (inf0 && inf1) || (zero0 && zero1))
      sp_in = SP_NAN;
    else if (inf0)
      sp_in = SP_INF;
    else if (zero1)
      sp_in = SP_DZ;
    else if (inf1 || zero0)
      sp_in = SP_ZERO;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = ITER;
      ITER:    if (cnt == CW'(1)) state_nxt = NORM;
      NORM:    state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.res       = res_r;
  assign bus.flags     = flags_r;

  assign rem_ge  = (rem >= dvs);
  assign rem_nxt = rem_ge ? {rem[F:0] - dvs[F:0], 1'b0} : {rem[F:0], 1'b0};

  always_comb begin
    msb      = q[F+2];
    frac     = msb ? q[F+1:2] : q[F:1];
    guard    = msb ? q[1] : q[0];
    exp_n    = msb ? exp_r : exp_r - EXP_ONE;
    round_up = (ROUNDING_TYPE == 1) && guard;
    sig_rnd  = {1'b0, frac} + {{F{1'b0}}, round_up};
    exp_f    = sig_rnd[F] ? exp_n + EXP_ONE : exp_n;
    inexact  = guard | (rem != '0);
    res_n    = '0;
    flags_n  = '0;
    case (sp)
      SP_NAN: begin
        res_n   = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};
        flags_n = 5'b10000;
      end
      SP_DZ: begin
        res_n   = {sign, {E{1'b1}}, {F{1'b0}}};
        flags_n = 5'b01000;
      end
      SP_INF:  res_n = {sign, {E{1'b1}}, {F{1'b0}}};
      SP_ZERO: res_n = {sign, {(BIT_SIZE-1){1'b0}}};
      default: begin
        if (exp_f >= EXP_MAX) begin
          res_n   = {sign, {E{1'b1}}, {F{1'b0}}};
          flags_n = 5'b00100;
        end else if (exp_f <= EXP_ZERO) begin
          res_n   = {sign, {(BIT_SIZE-1){1'b0}}};
          flags_n = 5'b00010;
        end else begin
          res_n   = {sign, exp_f[E-1:0], sig_rnd[F-1:0]};
          flags_n = {4'b0000, inexact};
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem     <= '0;
      dvs     <= '0;
      q       <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      exp_r   <= '0;
      sp      <= SP_NONE;
      res_r   <= '0;
      flags_r <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          rem   <= {2'b01, f0};
          dvs   <= {2'b01, f1};
          q     <= '0;
          cnt   <= CW'(F + 3);
          sign  <= s0 ^ s1;
          exp_r <= exp_in;
          sp    <= sp_in;
        end
        ITER: begin
          rem <= rem_nxt;
          q   <= {q[F+1:0], rem_ge};
          cnt <= cnt - CW'(1);
        end
        NORM: begin
          res_r   <= res_n;
          flags_r <= flags_n;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_divider.sv
// Self-checking bench: directed vector table, reset corner cases and random
// binary32 operands against an integer-division reference model.
module tb_fp_divider;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fp_divider_if #(.BIT_SIZE(32)) bus_t ();
  fp_divider_if #(.BIT_SIZE(32)) bus_r ();

  fp_divider #(.BIT_SIZE(32), .ROUNDING_TYPE(0)) u_trunc (.clk(clk), .rst_n(rst_n), .bus(bus_t));
  fp_divider #(.BIT_SIZE(32), .ROUNDING_TYPE(1)) u_round (.clk(clk), .rst_n(rst_n), .bus(bus_r));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rt;
    logic [31:0] rr;
    logic [4:0]  f;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: quotient from plain integer division of the scaled significands.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input bit rnd,
                                  output logic [31:0] r, output logic [4:0] f);
    int ea, eb, e;
    bit s, z0, z1, i0, i1, n0, n1, g;
    longint unsigned m0, m1, num, qq, rm, frac;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    z0 = (ea == 0);
    z1 = (eb == 0);
    i0 = (ea == 255) && (a[22:0] == 0);
    i1 = (eb == 255) && (b[22:0] == 0);
    n0 = (ea == 255) && (a[22:0] != 0);
    n1 = (eb == 255) && (b[22:0] != 0);
    f  = 5'b00000;
    if (n0 || n1 || (i0 && i1) || (z0 && z1)) begin
      r = 32'h7FC00000; f = 5'b10000; return;
    end
    if (i0) begin r = {s, 8'hFF, 23'h0}; return; end
    if (z1) begin r = {s, 8'hFF, 23'h0}; f = 5'b01000; return; end
    if (i1 || z0) begin r = {s, 31'h0}; return; end
    m0   = 64'(a[22:0]) + (64'd1 << 23);
    m1   = 64'(b[22:0]) + (64'd1 << 23);
    num  = m0 << 25;
    qq   = num / m1;
    rm   = num % m1;
    e    = ea - eb + 127;
    if (qq >= (64'd1 << 25)) begin
      frac = (qq >> 2) & 64'h7FFFFF;
      g    = qq[1];
    end else begin
      frac = (qq >> 1) & 64'h7FFFFF;
      g    = qq[0];
      e    = e - 1;
    end
    if (rnd && g) begin
      frac = frac + 1;
      if (frac == (64'd1 << 23)) begin frac = 0; e = e + 1; end
    end
    if (e >= 255) begin
      r = {s, 8'hFF, 23'h0}; f = 5'b00100;
    end else if (e <= 0) begin
      r = {s, 31'h0}; f = 5'b00010;
    end else begin
      r = {s, e[7:0], frac[22:0]};
      f = {4'b0000, g | (rm != 0)};
    end
  endfunction

  task automatic drive_in(input logic v, input logic [31:0] a, input logic [31:0] b);
    bus_t.in_valid = v; bus_t.num0 = a; bus_t.num1 = b;
    bus_r.in_valid = v; bus_r.num0 = a; bus_r.num1 = b;
  endtask

  task automatic set_ready(input logic v);
    bus_t.out_ready = v;
    bus_r.out_ready = v;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_t, input logic [31:0] exp_r,
                       input logic [4:0] ef_t, input logic [4:0] ef_r,
                       input int bp, input bit hold, input string tag);
    int lat;
    logic [31:0] res_s;
    logic [4:0]  flg_s;
    @(negedge clk);
    chk({tag, " in_ready before"}, {63'd0, bus_t.in_ready & bus_r.in_ready}, 64'd1);
    drive_in(1'b1, a, b);
    set_ready(hold);
    @(posedge clk); #1;
    drive_in(1'b0, $urandom, $urandom);
    lat = 0;
    while (!bus_t.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, 64'(lat), 64'd27);
    chk({tag, " round out_valid"}, {63'd0, bus_r.out_valid}, 64'd1);
    chk({tag, " res trunc"}, {32'd0, bus_t.res}, {32'd0, exp_t});
    chk({tag, " res round"}, {32'd0, bus_r.res}, {32'd0, exp_r});
    chk({tag, " flags trunc"}, {59'd0, bus_t.flags}, {59'd0, ef_t});
    chk({tag, " flags round"}, {59'd0, bus_r.flags}, {59'd0, ef_r});
    res_s = bus_t.res;
    flg_s = bus_t.flags;
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold res"}, {32'd0, bus_t.res}, {32'd0, res_s});
      chk({tag, " hold flags"}, {59'd0, bus_t.flags}, {59'd0, flg_s});
      chk({tag, " hold in_ready"}, {63'd0, bus_t.in_ready}, 64'd0);
      chk({tag, " hold out_valid"}, {63'd0, bus_t.out_valid}, 64'd1);
    end
    chk({tag, " in_ready at handshake"}, {63'd0, bus_t.in_ready}, 64'd0);
    set_ready(1'b1);
    @(posedge clk); #1;
    chk({tag, " out_valid after hs"}, {63'd0, bus_t.out_valid | bus_r.out_valid}, 64'd0);
    chk({tag, " in_ready after hs"}, {63'd0, bus_t.in_ready & bus_r.in_ready}, 64'd1);
    if (hold) begin
      @(posedge clk); #1;
      chk({tag, " no duplicate"}, {63'd0, bus_t.out_valid | bus_r.out_valid}, 64'd0);
    end
    set_ready(1'b0);
  endtask

  task automatic model_op(input logic [31:0] a, input logic [31:0] b, input bit hold, input string tag);
    logic [31:0] rt, rr;
    logic [4:0]  ft, fr;
    ref_div(a, b, 1'b0, rt, ft);
    ref_div(a, b, 1'b1, rr, fr);
    do_op(a, b, rt, rr, ft, fr, 0, hold, tag);
  endtask

  initial begin
    logic [31:0] a, b;
    int n;
    logic [31:0] edge_a[5];
    logic [31:0] edge_b[5];

    vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 5'b00000};
    vecs[1]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 32'h3EAAAAAB, 5'b00001};
    vecs[2]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 5'b01000};
    vecs[3]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 32'h7FC00000, 5'b10000};
    vecs[4]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 32'h7F800000, 5'b00100};
    vecs[5]  = '{32'h00800000, 32'h47000000, 32'h00000000, 32'h00000000, 5'b00010};
    vecs[6]  = '{32'h7F800000, 32'h40000000, 32'h7F800000, 32'h7F800000, 5'b00000};
    vecs[7]  = '{32'h40000000, 32'h7F800000, 32'h00000000, 32'h00000000, 5'b00000};
    vecs[8]  = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 5'b10000};
    vecs[9]  = '{32'hC0C00000, 32'h40000000, 32'hC0400000, 32'hC0400000, 5'b00000};
    vecs[10] = '{32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7FC00000, 5'b10000};
    vecs[11] = '{32'h00000000, 32'hC0A00000, 32'h80000000, 32'h80000000, 5'b00000};

    edge_a = '{32'h3FFFFFFF, 32'h7F7FFFFF, 32'h00800000, 32'h00800000, 32'h00000001};
    edge_b = '{32'h3F800001, 32'h3F000000, 32'h3F800001, 32'h3F800000, 32'h3F800000};

    drive_in(1'b0, 32'h0, 32'h0);
    set_ready(1'b0);
    #12;
    chk("reset in_ready", {63'd0, bus_t.in_ready & bus_r.in_ready}, 64'd1);
    chk("reset out_valid", {63'd0, bus_t.out_valid | bus_r.out_valid}, 64'd0);
    chk("reset res", {32'd0, bus_t.res | bus_r.res}, 64'd0);
    chk("reset flags", {59'd0, bus_t.flags | bus_r.flags}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++)
      do_op(vecs[i].a, vecs[i].b, vecs[i].rt, vecs[i].rr, vecs[i].f, vecs[i].f,
            (i == 0) ? 5 : 0, (i == 3), $sformatf("vec%0d", i));

    // Abort mid-iteration: outputs fall back asynchronously, nothing emerges.
    @(negedge clk);
    drive_in(1'b1, 32'h40C00000, 32'h40000000);
    @(posedge clk); #1;
    drive_in(1'b0, 32'h0, 32'h0);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort out_valid", {63'd0, bus_t.out_valid | bus_r.out_valid}, 64'd0);
    chk("abort in_ready", {63'd0, bus_t.in_ready & bus_r.in_ready}, 64'd1);
    chk("abort res", {32'd0, bus_t.res}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (35) begin
      @(posedge clk); #1;
      if (bus_t.out_valid || bus_r.out_valid) n++;
    end
    chk("abort no result", 64'(n), 64'd0);
    do_op(32'h40C00000, 32'h40000000, 32'h40400000, 32'h40400000, 5'b0, 5'b0, 0, 1'b0, "after abort");

    // Reset while a result is waiting in DONE.
    @(negedge clk);
    drive_in(1'b1, 32'h3F800000, 32'h40400000);
    @(posedge clk); #1;
    drive_in(1'b0, 32'h0, 32'h0);
    n = 0;
    while (!bus_t.out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done reached", {63'd0, bus_t.out_valid}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("done abort out_valid", {63'd0, bus_t.out_valid | bus_r.out_valid}, 64'd0);
    chk("done abort flags", {59'd0, bus_t.flags | bus_r.flags}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      model_op(edge_a[i], edge_b[i], 1'b0, $sformatf("edge%0d", i));

    for (int k = 0; k < 150; k++) begin
      a = $urandom;
      b = $urandom;
      if (k % 5 != 0) begin
        a[30:23] = 8'($urandom_range(60, 190));
        b[30:23] = 8'($urandom_range(60, 190));
      end
      model_op(a, b, (k % 7 == 0), $sformatf("rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Iterative IEEE-754 floating-point divider; computes res = num0 / num1 for binary32 or binary64.
- Companion to the combinational adder in the floating-point arithmetic unit.
- Uses a restoring radix-2 mantissa divider that produces one quotient bit per cycle.
- Has valid/ready handshakes on input and output; one operation in flight at a time.

Parameters:
- BIT_SIZE, 32: operand width. 32 gives E=8, F=23; 64 gives E=11, F=52. Any other value is an elaboration error.
- ROUNDING_TYPE, 0: 0 truncates; 1 rounds half-up using the guard bit.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operands valid.
- in_ready  out  1  divider can accept operands.
- num0  in  BIT_SIZE  dividend.
- num1  in  BIT_SIZE  divisor.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- res  out  BIT_SIZE  quotient.
- flags  out  5  {invalid, div_by_zero, overflow, underflow, inexact}.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state IDLE, in_ready=1, out_valid=0, res=0, flags=0. All internal registers are cleared.
- FSM states: IDLE, ITER, NORM, DONE.
  - IDLE: in_ready=1. On in_valid&&in_ready, latch the operands and classify them. Load rem={1'b1,frac0} and div={1'b1,frac1}. Set the counter to F+3, then go to ITER.
  - ITER: each cycle, if rem>=div then q bit=1 and rem=(rem-div)<<1; else q bit=0 and rem=rem<<1. The q register shifts left. The counter decrements; at 1, go to NORM. rem and div are F+2 bits wide.
  - NORM: normalize, round, and apply special cases. Register res and flags, then go to DONE.
  - DONE: out_valid=1. res and flags hold stable until out_ready. On out_valid&&out_ready, go to IDLE.
- in_ready rises the cycle after the output handshake, not in the same cycle.
- Latency is fixed: out_valid rises F+4 cycles after the accepting edge (27 for binary32). Special cases also run the full iteration count.
- q is F+3 bits; q[F+2] has weight 2^0.
- Normalization when q[F+2]=1: frac=q[F+1:2], guard=q[1], exp=e0-e1+bias.
- Normalization when q[F+2]=0: frac=q[F:1], guard=q[0], exp=e0-e1+bias-1.
- Rounding (ROUNDING_TYPE=1, guard=1): the significand increments. A carry out gives frac=0 and exp+1.
- Exponent arithmetic is signed, E+2 bits wide.
  - exp>=2^E-1 gives signed infinity and sets overflow.
  - exp<=0 flushes to signed zero and sets underflow.
- inexact = guard | (rem!=0), for normal results only.
- Subnormal inputs are treated as zero. Subnormal outputs are never produced.
- Special cases, decided at accept and applied in NORM. Sign is s0^s1 except for NaN.
  - Any NaN operand, inf/inf, or 0/0: canonical qNaN (0x7FC00000 / 0x7FF8000000000000), invalid=1.
  - Finite nonzero / 0: signed infinity, div_by_zero=1.
  - inf / finite: signed infinity, no flags.
  - finite / inf, or 0 / nonzero finite: signed zero, no flags.
- in_valid while busy is ignored; operands are not sampled.
- rst_n low at any time, including mid-ITER or in DONE, aborts the operation. All outputs return to reset values asynchronously, and no result is emitted.
- out_ready held high continuously still gives one result per operation, with no duplicate handshake.

Test Plan:
- 0x40C00000 / 0x40000000 (6/2) -> res=0x40400000, flags=0, out_valid exactly 27 cycles after the accept.
- 0x3F800000 / 0x40400000 (1/3) -> ROUNDING_TYPE=0: 0x3EAAAAAA; ROUNDING_TYPE=1: 0x3EAAAAAB. inexact=1 in both.
- 0x3F800000 / 0x00000000 -> 0x7F800000, div_by_zero=1.
- 0x00000000 / 0x00000000 -> 0x7FC00000, invalid=1.
- 0x7F000000 / 0x3E800000 -> 0x7F800000, overflow=1.
- 0x00800000 / 0x47000000 -> 0x00000000, underflow=1.
- Backpressure: out_ready low for 5 cycles after out_valid -> res and flags stable, in_ready=0. in_ready=1 the cycle after the handshake.
- rst_n pulsed low at iteration 10 -> out_valid=0 and in_ready=1 immediately. The next op, 6/2, returns 0x40400000.
